wheel_window_sched: RTL and testbench
=====================================

// Module: wheel_window_sched
// PURPOSE
//  Scheduler for the wheel_speed pulse counters. Generates a fixed measurement window,
//  snapshots all N wheel counts at window end, and issues a 1-cycle clear to the counters.
//  Drains the snapshot one wheel per transfer over a valid/ready stream to the odometry core.
//  Sits between the per-wheel wheel_speed instances and the odometry integrator.
// PARAMETERS
//  N_WHEELS  4     number of wheel_speed channels (1..8)
//  CNT_W     8     width of each pulse count
//  TMR_W     16    width of window timer / window_len
//  OVR_W     8     width of saturating overrun counter
// PORTS
//  CLK        in   1             system clock, rising edge
//  RST        in   1             asynchronous reset, active-high
//  enable     in   1             1 = run windows; 0 = idle, timer held at 0
//  window_len in   TMR_W         window length in CLK cycles, sampled at each window start
//  pulse_cnt  in   N_WHEELS*CNT_W  packed counts, wheel i at [i*CNT_W +: CNT_W]
//  ws_clear   out  1             1-cycle clear to all wheel_speed counters
//  out_valid  out  1             stream valid
//  out_ready  in   1             stream ready from consumer
//  out_id     out  3             wheel index of current word
//  out_count  out  CNT_W         snapshot count of wheel out_id
//  out_last   out  1             high with word of wheel N_WHEELS-1
//  frame_drop out  1             1-cycle pulse: snapshot lost to overrun
//  ovr_cnt    out  OVR_W         saturating count of dropped frames
// BEHAVIOUR
//  - Reset (async, RST=1): timer=0, ws_clear=0, out_valid=0, out_id=0, out_count=0,
//    out_last=0, frame_drop=0, ovr_cnt=0, snapshot=0, FSM in IDLE.
//  - Window timer: when enable=1, loads len=max(window_len,2) at window start, counts 0..len-1.
//    On terminal cycle (timer==len-1): window_end=1 for one cycle; timer restarts at 0 next cycle.
//  - window_end: same cycle asserts ws_clear next cycle (registered, 1 cycle); snapshot of
//    pulse_cnt taken on the window_end edge, i.e. before counters are cleared.
//  - Sender FSM: IDLE -> SEND on snapshot capture; in SEND out_valid=1, out_id=k,
//    out_count=snap[k]; k advances when out_valid&&out_ready; after k=N_WHEELS-1 transfer
//    -> IDLE (out_valid=0 same edge). out_count/out_id stable while valid&&!ready.
//  - First word valid 1 cycle after window_end; back-to-back words when ready held high.
//  - Overrun: window_end while FSM in SEND -> snapshot NOT overwritten, frame_drop=1 for
//    1 cycle, ovr_cnt+=1 saturating at all-ones; ws_clear still issued.
//  - window_end on same cycle as final handshake: counts as no overrun; new snapshot
//    captured, FSM stays in SEND with k=0 (no idle bubble).
//  - enable 1->0 mid-window: timer->0, ws_clear pulsed once (discard partial window),
//    no snapshot; any in-progress send completes normally. enable 0->1: new window at 0.
//  - window_len changes mid-window take effect only at next window start.
//  - Timer width: len fits TMR_W; no wrap inside a window.
// STRUCTURE
//  - Shared package odo_pkg: sender state enum {IDLE, SEND}, MIN_WINDOW=2,
//    wheel index width constant ID_W=3.
//  - One sub-module: window_timer (enable, window_len -> window_end, abort_clear);
//    sender FSM, snapshot registers and overrun logic in top.
// TESTING
//  1. RST mid-SEND (async, between clocks) -> all outputs 0 immediately; IDLE after release.
//  2. window_len=10, counts {3,7,0,255}, ready=1 -> window_end every 10 cycles; ws_clear 1
//     cycle after; 4 words id 0..3 counts 3,7,0,255 on consecutive cycles, out_last on id 3.
//  3. window_len=4, ready=0 -> second window_end: frame_drop pulse, ovr_cnt=1, out_count
//     still holds first snapshot; after 300 windows ovr_cnt=255 (saturated).
//  4. ready toggling 1/0 every cycle -> each word held stable while ready=0; no word lost
//     or duplicated; 4 handshakes total per frame.
//  5. window_len=0 and 1 -> treated as 2: window_end every 2 cycles.
//  6. enable dropped at timer=5 of 10 -> single ws_clear, no snapshot, no frame_drop;
//     re-enable -> next window_end exactly 10 cycles later.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared types and constants for the wheel odometry front end.
package odo_pkg;

  typedef enum logic {
    IDLE,
    SEND
  } send_state_e;

  localparam int unsigned MIN_WINDOW = 2;
  localparam int unsigned ID_W       = 3;

endpackage

// File: rtl/wheel_window_sched_if.sv
// Valid/ready stream carrying one wheel snapshot word per transfer.
interface wheel_window_sched_if
  import odo_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) ();

  logic             out_valid;
  logic             out_ready;
  logic [ID_W-1:0]  out_id;
  logic [CNT_W-1:0] out_count;
  logic             out_last;

  modport master (
    output out_valid,
    output out_id,
    output out_count,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_id,
    input  out_count,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/window_timer.sv
// Measurement window timer: flags the last cycle of each window and any aborted window.
module window_timer
  import odo_pkg::*;
#(
  parameter int unsigned TMR_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             enable,
  input  logic [TMR_W-1:0] window_len,
  output logic             window_end,
  output logic             abort_clear
);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [TMR_W-1:0] len_q;
  logic [TMR_W-1:0] clamped_len;
  logic [TMR_W-1:0] cur_len;
  logic             run_q;

  always_comb begin
    clamped_len = (window_len < TMR_W'(MIN_WINDOW)) ? TMR_W'(MIN_WINDOW) : window_len;
    // Length is latched on the first cycle of a window; later changes wait for the next one.
    cur_len     = (tmr_q == '0) ? clamped_len : len_q;
    window_end  = enable && (tmr_q == cur_len - TMR_W'(1));
    abort_clear = run_q && !enable;
    tmr_d       = (!enable || window_end) ? '0 : tmr_q + TMR_W'(1);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tmr_q <= '0;
      len_q <= TMR_W'(MIN_WINDOW);
      run_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      run_q <= enable;
      if (enable && (tmr_q == '0)) begin
        len_q <= clamped_len;
      end
    end
  end

endmodule

// File: rtl/wheel_window_sched.sv
// Windowed snapshot of all wheel pulse counters, drained one wheel per stream transfer.
module wheel_window_sched
  import odo_pkg::*;
#(
  parameter int unsigned N_WHEELS = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned TMR_W    = 16,
  parameter int unsigned OVR_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      enable,
  input  logic [TMR_W-1:0]          window_len,
  input  logic [N_WHEELS*CNT_W-1:0] pulse_cnt,
  output logic                      ws_clear,
  output logic                      frame_drop,
  output logic [OVR_W-1:0]          ovr_cnt,
  wheel_window_sched_if.master      os
);

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_WHEELS - 1);

  send_state_e      state_q, state_d;
  logic [ID_W-1:0]  k_q, k_d;
  logic [CNT_W-1:0] snap_q [N_WHEELS];

  logic window_end;
  logic abort_clear;
  logic hs;
  logic final_hs;
  logic capture;
  logic overrun;

  window_timer #(
    .TMR_W (TMR_W)
  ) u_timer (
    .CLK         (CLK),
    .RST         (RST),
    .enable      (enable),
    .window_len  (window_len),
    .window_end  (window_end),
    .abort_clear (abort_clear)
  );

  // A window ending on the final handshake reloads the snapshot instead of dropping it.
  assign hs       = (state_q == SEND) && os.out_ready;
  assign final_hs = hs && (k_q == LAST_ID);
  assign capture  = window_end && ((state_q == IDLE) || final_hs);
  assign overrun  = window_end && !capture;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          k_d     = '0;
        end
      end
      SEND: begin
        if (final_hs) begin
          state_d = capture ? SEND : IDLE;
          k_d     = '0;
        end else if (hs) begin
          k_d = k_q + ID_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  always_comb begin
    os.out_valid = (state_q == SEND);
    os.out_id    = k_q;
    os.out_last  = (state_q == SEND) && (k_q == LAST_ID);
    os.out_count = '0;
    for (int i = 0; i < N_WHEELS; i++) begin
      if (k_q == ID_W'(i)) begin
        os.out_count = snap_q[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ws_clear   <= 1'b0;
      frame_drop <= 1'b0;
      ovr_cnt    <= '0;
      for (int i = 0; i < N_WHEELS; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      ws_clear   <= window_end || abort_clear;
      frame_drop <= overrun;
      if (overrun && (ovr_cnt != '1)) begin
        ovr_cnt <= ovr_cnt + OVR_W'(1);
      end
      if (capture) begin
        for (int i = 0; i < N_WHEELS; i++) begin
          snap_q[i] <= pulse_cnt[i*CNT_W +: CNT_W];
        end
      end
    end
  end

endmodule

// File: tb/tb_wheel_window_sched.sv
// Scoreboard bench: a window/frame model predicts stream words and clear/drop pulses.
module tb_wheel_window_sched;
  import odo_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int TW = 16;
  localparam int OW = 8;

  logic            CLK = 1'b0;
  logic            RST;
  logic            enable;
  logic [TW-1:0]   window_len;
  logic [N*CW-1:0] pulse_cnt;
  logic            ws_clear;
  logic            frame_drop;
  logic [OW-1:0]   ovr_cnt;

  wheel_window_sched_if #(.CNT_W(CW)) sif ();

  wheel_window_sched #(
    .N_WHEELS (N),
    .CNT_W    (CW),
    .TMR_W    (TW),
    .OVR_W    (OW)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .enable     (enable),
    .window_len (window_len),
    .pulse_cnt  (pulse_cnt),
    .ws_clear   (ws_clear),
    .frame_drop (frame_drop),
    .ovr_cnt    (ovr_cnt),
    .os         (sif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int id;
    int cnt;
    int last;
  } word_t;

  word_t exp_q[$];
  int    errors = 0;
  int    checks = 0;

  // Model state: position in window, window length, words still owed, overrun count.
  int m_t = 0, m_len = 2, m_rem = 0, m_ovr = 0;
  int m_prev_en = 0, m_clr = 0, m_drop = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_step();
    int    we, abort, hs;
    word_t w;
    if (RST) begin
      m_t = 0; m_len = 2; m_rem = 0; m_ovr = 0;
      m_prev_en = 0; m_clr = 0; m_drop = 0;
      exp_q.delete();
      return;
    end
    we    = 0;
    abort = 0;
    hs    = (m_rem > 0 && sif.out_ready) ? 1 : 0;
    if (enable) begin
      if (m_t == 0) m_len = (window_len < 2) ? 2 : int'(window_len);
      we  = (m_t == m_len - 1) ? 1 : 0;
      m_t = we ? 0 : m_t + 1;
    end else begin
      abort = m_prev_en;
      m_t   = 0;
    end
    m_prev_en = enable ? 1 : 0;
    m_clr     = we | abort;
    m_drop    = 0;
    if (hs) m_rem--;
    if (we) begin
      if (m_rem == 0) begin
        for (int i = 0; i < N; i++) begin
          w.id   = i;
          w.cnt  = int'(pulse_cnt[i*CW +: CW]);
          w.last = (i == N - 1) ? 1 : 0;
          exp_q.push_back(w);
        end
        m_rem = N;
      end else begin
        m_drop = 1;
        if (m_ovr < 255) m_ovr++;
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    model_step();
  end

  // Monitor: compare on the falling edge, pop the expected word on each handshake.
  initial forever begin
    @(negedge CLK);
    check("out_valid", int'(sif.out_valid), (m_rem > 0) ? 1 : 0);
    check("ws_clear", int'(ws_clear), m_clr);
    check("frame_drop", int'(frame_drop), m_drop);
    check("ovr_cnt", int'(ovr_cnt), m_ovr);
    if (sif.out_valid && exp_q.size() > 0) begin
      check("out_id", int'(sif.out_id), exp_q[0].id);
      check("out_count", int'(sif.out_count), exp_q[0].cnt);
      check("out_last", int'(sif.out_last), exp_q[0].last);
      if (sif.out_ready) void'(exp_q.pop_front());
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    int n;
    int clr_seen;
    int drop_seen;
    RST            = 1'b1;
    enable         = 1'b0;
    window_len     = '0;
    pulse_cnt      = '0;
    sif.out_ready  = 1'b0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    check("rst_ovr_cnt", int'(ovr_cnt), 0);
    check("rst_out_valid", int'(sif.out_valid), 0);

    // Fixed counts, always-ready consumer.
    pulse_cnt     = 32'hFF00_0703;
    window_len    = 16'd10;
    sif.out_ready = 1'b1;
    enable        = 1'b1;
    cyc(45);

    // Stalled consumer: every later window overruns until the counter saturates.
    window_len    = 16'd4;
    sif.out_ready = 1'b0;
    for (int i = 0; i < 1220; i++) begin
      pulse_cnt = $urandom;
      cyc(1);
    end
    check("ovr_saturated", int'(ovr_cnt), 255);
    sif.out_ready = 1'b1;
    cyc(20);

    // Asynchronous reset while a frame is being sent.
    window_len    = 16'd6;
    sif.out_ready = 1'b0;
    n = 0;
    while (!sif.out_valid && n < 50) begin
      cyc(1);
      n++;
    end
    check("valid_before_rst", int'(sif.out_valid), 1);
    @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    check("arst_valid", int'(sif.out_valid), 0);
    check("arst_id", int'(sif.out_id), 0);
    check("arst_count", int'(sif.out_count), 0);
    check("arst_last", int'(sif.out_last), 0);
    check("arst_ovr", int'(ovr_cnt), 0);
    check("arst_clear", int'(ws_clear), 0);
    check("arst_drop", int'(frame_drop), 0);
    cyc(2);
    RST = 1'b0;
    check("post_rst_valid", int'(sif.out_valid), 0);

    // Consumer ready toggling every cycle.
    window_len    = 16'd12;
    sif.out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sif.out_ready = ~sif.out_ready;
      pulse_cnt     = $urandom;
      cyc(1);
    end

    // Degenerate lengths clamp to two cycles.
    sif.out_ready = 1'b1;
    window_len    = 16'd0;
    for (int i = 0; i < 30; i++) begin
      pulse_cnt = $urandom;
      cyc(1);
    end
    window_len = 16'd1;
    cyc(30);
    clr_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (ws_clear) clr_seen++;
      cyc(1);
    end
    check("len1_clear_rate", clr_seen, 10);

    // Enable dropped mid-window, then restarted.
    window_len = 16'd10;
    n = 0;
    while (m_t != 5 && n < 60) begin
      cyc(1);
      n++;
    end
    check("reached_t5", m_t, 5);
    enable    = 1'b0;
    clr_seen  = 0;
    drop_seen = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (ws_clear) clr_seen++;
      if (frame_drop) drop_seen++;
    end
    check("abort_clear_count", clr_seen, 1);
    check("abort_drop_count", drop_seen, 0);
    enable = 1'b1;
    n = 0;
    do begin
      cyc(1);
      n++;
    end while (!ws_clear && n < 30);
    check("reenable_latency", n, 10);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      enable        = ($urandom_range(0, 19) != 0);
      sif.out_ready = $urandom_range(0, 1) != 0;
      pulse_cnt     = $urandom;
      if ($urandom_range(0, 9) == 0) window_len = TW'($urandom_range(0, 12));
      cyc(1);
    end

    enable        = 1'b0;
    sif.out_ready = 1'b1;
    cyc(20);
    check("drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
